// File: rtl/immediate_unit_pkg.sv
// immediate_unit_pkg: shared opcodes, immediate-type codes and skid-buffer states
package immediate_unit_pkg;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [2:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [2:0] IMM_TYPE_I    = 3'd1;
  localparam logic [2:0] IMM_TYPE_S    = 3'd2;
  localparam logic [2:0] IMM_TYPE_B    = 3'd3;
  localparam logic [2:0] IMM_TYPE_U    = 3'd4;
  localparam logic [2:0] IMM_TYPE_J    = 3'd5;
  localparam logic [2:0] IMM_TYPE_Z    = 3'd6;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_t;
endpackage

// File: rtl/immediate_unit_decode.sv
// immediate_decode: combinational immediate decode, format classification and pc+imm target
//   inst/pc in; imm (sign-extended to XLEN), imm_type (IMM_TYPE_*), target = pc + imm out
module immediate_decode
  import immediate_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ENABLE_ZICSR = 1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] target
);
  // every format fits in 32 bits; Z is zero-extended there so one sign-extension serves all
  logic [31:0] imm32;
  always_comb begin
    imm_type = IMM_TYPE_NONE;
    imm32    = '0;
    case (inst[6:0])
      OPCODE_LOAD, OPCODE_LOAD_FP, OPCODE_OP_IMM, OPCODE_JALR: begin
        imm_type = IMM_TYPE_I;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      OPCODE_OP_IMM_32: if (XLEN == 64) begin
        imm_type = IMM_TYPE_I;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      OPCODE_STORE, OPCODE_STORE_FP: begin
        imm_type = IMM_TYPE_S;
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPCODE_BRANCH: begin
        imm_type = IMM_TYPE_B;
        imm32    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm_type = IMM_TYPE_U;
        imm32    = {inst[31:12], 12'b0};
      end
      OPCODE_JAL: begin
        imm_type = IMM_TYPE_J;
        imm32    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPCODE_SYSTEM: if (ENABLE_ZICSR && inst[14] && inst[13:12] != 2'b00) begin
        imm_type = IMM_TYPE_Z;
        imm32    = {27'b0, inst[19:15]};
      end
      default: ;
    endcase
  end
  assign imm    = XLEN'($signed(imm32));
  assign target = pc + imm;
endmodule

// File: rtl/immediate_unit.sv
// immediate_unit: registered immediate decode behind a 2-entry valid/ready skid buffer
//   clock/reset_n (async, active-low), flush; in_valid/in_ready/in_inst/in_pc upstream;
//   out_valid/out_ready/out_inst/out_pc/out_imm/out_imm_type/out_target downstream
module immediate_unit
  import immediate_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ENABLE_ZICSR = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic [XLEN-1:0] out_target
);
  buf_state_t state, state_next;
  logic [XLEN-1:0] dec_imm, dec_target, skid_pc, skid_imm, skid_target;
  logic [2:0] dec_type, skid_type;
  logic [31:0] skid_inst;
  logic accept, load_main, load_skid, promote;
  immediate_decode #(.XLEN(XLEN), .ENABLE_ZICSR(ENABLE_ZICSR)) u_decode (
    .inst(in_inst), .pc(in_pc), .imm(dec_imm), .imm_type(dec_type), .target(dec_target)
  );
  // ready comes only from registered state and flush, never from out_ready
  assign in_ready  = state != BUF_TWO && !flush;
  assign out_valid = state != BUF_EMPTY;
  assign accept    = in_valid && in_ready;
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    promote    = 1'b0;
    case (state)
      BUF_EMPTY: if (accept) begin
        state_next = BUF_ONE;
        load_main  = 1'b1;
      end
      BUF_ONE: if (accept && out_ready) load_main = 1'b1;
        else if (accept) begin
          load_skid  = 1'b1;
          state_next = BUF_TWO;
        end else if (out_ready) state_next = BUF_EMPTY;
      BUF_TWO: if (out_ready) begin
        promote    = 1'b1;
        state_next = BUF_ONE;
      end
      default: state_next = BUF_EMPTY;
    endcase
    // flush wins over out_ready; accept is already blocked through in_ready
    if (flush) begin
      state_next = BUF_EMPTY;
      promote    = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BUF_EMPTY;
      out_inst     <= '0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_imm_type <= IMM_TYPE_NONE;
      out_target   <= '0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_imm     <= '0;
      skid_type    <= IMM_TYPE_NONE;
      skid_target  <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        out_inst     <= in_inst;
        out_pc       <= in_pc;
        out_imm      <= dec_imm;
        out_imm_type <= dec_type;
        out_target   <= dec_target;
      end else if (promote) begin
        out_inst     <= skid_inst;
        out_pc       <= skid_pc;
        out_imm      <= skid_imm;
        out_imm_type <= skid_type;
        out_target   <= skid_target;
      end
      if (load_skid) begin
        skid_inst   <= in_inst;
        skid_pc     <= in_pc;
        skid_imm    <= dec_imm;
        skid_type   <= dec_type;
        skid_target <= dec_target;
      end
    end
  end
endmodule

// File: tb/tb_immediate_unit.sv
// tb_immediate_unit: scoreboard bench for immediate_unit (XLEN=32, XLEN=64, XLEN=64 without Zicsr)
module tb_immediate_unit;
  logic clock = 0, reset_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic [63:0] in_pc64 = 0;
  logic in_ready, out_valid, in_ready64, out_valid64, in_ready_nz, out_valid_nz;
  logic [31:0] out_inst, out_pc, out_imm, out_target, out_inst64, out_inst_nz;
  logic [63:0] out_pc64, out_imm64, out_target64, out_pc_nz, out_imm_nz, out_target_nz;
  logic [2:0] out_imm_type, out_imm_type64, out_imm_type_nz;
  int n_checks = 0, n_fail = 0;
  typedef struct {logic [31:0] inst, pc, imm, target; logic [2:0] ty;} exp_t;
  exp_t sb[$];
  logic [31:0] tab_inst [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                                32'h800000B7, 32'h300FD073, 32'h00000033, 32'hFFF0009B};
  logic [31:0] tab_pc [8] = '{32'h0, 32'h0, 32'h100, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [2:0] tab_ty32 [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0, 3'd0};
  logic [31:0] tab_imm32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                 32'h80000000, 32'h0000001F, 32'h0, 32'h0};
  logic [2:0] tab_ty64 [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0, 3'd1};
  logic [63:0] tab_imm64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                 64'h800, 64'hFFFFFFFF80000000, 64'h1F, 64'h0, 64'hFFFFFFFFFFFFFFFF};
  immediate_unit #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_target(out_target)
  );
  immediate_unit #(.XLEN(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_inst(out_inst64), .out_pc(out_pc64), .out_imm(out_imm64), .out_imm_type(out_imm_type64),
    .out_target(out_target64)
  );
  immediate_unit #(.XLEN(64), .ENABLE_ZICSR(1'b0)) dut_nz (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_nz),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(out_valid_nz), .out_ready(out_ready),
    .out_inst(out_inst_nz), .out_pc(out_pc_nz), .out_imm(out_imm_nz), .out_imm_type(out_imm_type_nz),
    .out_target(out_target_nz)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset;
    #1 reset_n = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_imm_type !== 3'd0) begin n_fail++; $display("FAIL reset_imm_type: got %0d expected 0", out_imm_type); end
    n_checks++; if (out_imm !== 32'h0 || out_target !== 32'h0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got imm %h target %h pc %h inst %h expected all 0", out_imm, out_target, out_pc, out_inst); end
    tick; tick;
    @(negedge clock) reset_n = 1;
    tick;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
  endtask
  task automatic test_decode;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; out_ready = 1; in_inst = tab_inst[i]; in_pc = tab_pc[i]; in_pc64 = 64'(tab_pc[i]);
      tick;
      n_checks++; if (out_valid !== 1'b1 || out_inst !== tab_inst[i]) begin
        n_fail++; $display("FAIL dec32_valid[%0d]: got valid %b inst %h expected 1 %h", i, out_valid, out_inst, tab_inst[i]); end
      n_checks++; if (out_imm_type !== tab_ty32[i] || out_imm !== tab_imm32[i]) begin
        n_fail++; $display("FAIL dec32_imm[%0d]: got type %0d imm %h expected %0d %h", i, out_imm_type, out_imm, tab_ty32[i], tab_imm32[i]); end
      n_checks++; if (out_target !== tab_pc[i] + tab_imm32[i]) begin
        n_fail++; $display("FAIL dec32_target[%0d]: got %h expected %h", i, out_target, tab_pc[i] + tab_imm32[i]); end
      n_checks++; if (out_valid64 !== 1'b1 || out_imm_type64 !== tab_ty64[i] || out_imm64 !== tab_imm64[i]) begin
        n_fail++; $display("FAIL dec64_imm[%0d]: got valid %b type %0d imm %h expected 1 %0d %h", i, out_valid64, out_imm_type64, out_imm64, tab_ty64[i], tab_imm64[i]); end
      n_checks++; if (out_target64 !== 64'(tab_pc[i]) + tab_imm64[i]) begin
        n_fail++; $display("FAIL dec64_target[%0d]: got %h expected %h", i, out_target64, 64'(tab_pc[i]) + tab_imm64[i]); end
      n_checks++; if (out_imm_type_nz !== (i == 5 ? 3'd0 : tab_ty64[i]) || out_imm_nz !== (i == 5 ? 64'h0 : tab_imm64[i])) begin
        n_fail++; $display("FAIL dec64_nozicsr[%0d]: got type %0d imm %h expected %0d %h", i, out_imm_type_nz, out_imm_nz,
                           (i == 5 ? 3'd0 : tab_ty64[i]), (i == 5 ? 64'h0 : tab_imm64[i])); end
    end
    in_valid = 0;
    tick;
  endtask
  task automatic test_back_to_back;
    int idx = 0, received = 0;
    bit have_hold = 0;
    logic [31:0] hold_inst = 0, hold_imm = 0, hold_target = 0;
    exp_t e;
    sb.delete();
    for (int cyc = 0; cyc < 40 && received < 8; cyc++) begin
      in_valid = idx < 8;
      in_inst = tab_inst[idx % 8];
      in_pc = 32'h2000 + 32'(4 * idx);
      in_pc64 = 64'(in_pc);
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clock);
      if (cyc == 3) begin n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_c3: got %b expected 1", in_ready); end end
      if (cyc == 4) begin n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_c4: got %b expected 0", in_ready); end end
      if (out_valid && !out_ready && have_hold) begin
        n_checks++; if (out_inst !== hold_inst || out_imm !== hold_imm || out_target !== hold_target) begin
          n_fail++; $display("FAIL stall_stable c%0d: got %h %h %h expected %h %h %h", cyc, out_inst, out_imm, out_target, hold_inst, hold_imm, hold_target); end
      end
      have_hold = out_valid && !out_ready;
      hold_inst = out_inst; hold_imm = out_imm; hold_target = out_target;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got inst %h expected none", out_inst);
        end else begin
          e = sb.pop_front();
          if (out_inst !== e.inst || out_pc !== e.pc || out_imm !== e.imm || out_imm_type !== e.ty || out_target !== e.target) begin
            n_fail++; $display("FAIL stream_entry %0d: got %h %h %h %0d %h expected %h %h %h %0d %h", received,
                               out_inst, out_pc, out_imm, out_imm_type, out_target, e.inst, e.pc, e.imm, e.ty, e.target);
          end
        end
        received++;
      end
      if (in_valid && in_ready) begin
        e.inst = in_inst; e.pc = in_pc; e.imm = tab_imm32[idx]; e.ty = tab_ty32[idx]; e.target = in_pc + tab_imm32[idx];
        sb.push_back(e);
        idx++;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 0;
    n_checks++; if (received !== 8 || sb.size() != 0 || idx != 8) begin
      n_fail++; $display("FAIL stream_count: got received %0d left %0d sent %0d expected 8 0 8", received, sb.size(), idx); end
    tick;
  endtask
  task automatic test_flush;
    out_ready = 0; in_valid = 1; in_inst = tab_inst[0]; in_pc = 32'h40; in_pc64 = 64'h40;
    tick;
    in_inst = tab_inst[1];
    tick;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_two: got in_ready %b out_valid %b expected 0 1", in_ready, out_valid); end
    flush = 1; out_ready = 1; in_inst = tab_inst[2];
    #2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick;
    flush = 0; in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b expected 0", out_valid); end
  endtask
  task automatic test_reset_mid;
    out_ready = 1; in_valid = 1; in_inst = tab_inst[2]; in_pc = 32'h100; in_pc64 = 64'h100;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFF8) begin
      n_fail++; $display("FAIL mid_pre: got valid %b imm %h expected 1 fffffff8", out_valid, out_imm); end
    #1 reset_n = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_target !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got valid %b imm %h target %h in_ready %b expected 0 0 0 1", out_valid, out_imm, out_target, in_ready); end
    in_valid = 0;
    @(negedge clock) reset_n = 1;
    tick;
    in_valid = 1; in_inst = tab_inst[3]; in_pc = 32'h1000; in_pc64 = 64'h1000;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b expected 0", out_valid); end
    tick;
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || out_imm_type !== 3'd5 || out_target !== 32'h1800) begin
      n_fail++; $display("FAIL mid_first: got valid %b type %0d target %h expected 1 5 00001800", out_valid, out_imm_type, out_target); end
    tick;
  endtask
  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
